// File: rtl/eth_pkg.sv
// eth_pkg: frame phase encoding, schedule boundaries and fixed line dibits
// shared by the frame source and its helpers.
package eth_pkg;

    typedef enum logic [2:0] {
        PH_TAIL,
        PH_IFG,
        PH_PRE,
        PH_DEST,
        PH_SRC,
        PH_LEN,
        PH_DATA
    } phase_t;

    // First position of each phase; the data phase runs to the end of the frame.
    localparam int IFG_START  = 16;
    localparam int PRE_START  = 64;
    localparam int SFD_POS    = 95;
    localparam int DEST_START = 96;
    localparam int SRC_START  = 120;
    localparam int LEN_START  = 144;
    localparam int DATA_START = 152;

    localparam logic [1:0] PRE_DIBIT   = 2'b01;
    localparam logic [1:0] SFD_DIBIT   = 2'b11;
    localparam logic [1:0] BCAST_DIBIT = 2'b11;

    function automatic phase_t phase_of(input int pos);
        phase_t ph;
        if (pos < IFG_START)       ph = PH_TAIL;
        else if (pos < PRE_START)  ph = PH_IFG;
        else if (pos < DEST_START) ph = PH_PRE;
        else if (pos < SRC_START)  ph = PH_DEST;
        else if (pos < LEN_START)  ph = PH_SRC;
        else if (pos < DATA_START) ph = PH_LEN;
        else                       ph = PH_DATA;
        return ph;
    endfunction

endpackage

// File: rtl/byte_to_dibit.sv
// byte_to_dibit: picks dibit sel of a byte, least-significant dibit first.
module byte_to_dibit (
    input  logic [7:0] data,
    input  logic [1:0] sel,
    output logic [1:0] dibit
);

    // sel 0 -> bits [1:0], sel 3 -> bits [7:6]
    always_comb begin
        dibit = data[1:0];
        case (sel)
            2'd1:    dibit = data[3:2];
            2'd2:    dibit = data[5:4];
            2'd3:    dibit = data[7:6];
            default: dibit = data[1:0];
        endcase
    end

endmodule

// File: rtl/eth_frame_source.sv
// eth_frame_source: produces the dibit stream for eth_packer in lockstep with
// its fixed frame schedule. Payload bytes are buffered from an upstream FIFO.
// Optional macro ETH_SRC_SEQ_EN: first payload byte is an 8-bit frame counter.
module eth_frame_source
    import eth_pkg::*;
#(
    parameter int          PAYLOAD_BYTES = 5,
    parameter logic [47:0] SRC_MAC       = 48'h69695A065491
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic       stall,
    output logic       axiov,
    output logic [1:0] axiod,
    output logic       underrun,
    output logic       sync_err
);

    localparam int FRAME_LEN = DATA_START + 4 * PAYLOAD_BYTES;
    localparam int PW        = $clog2(FRAME_LEN);
`ifdef ETH_SRC_SEQ_EN
    localparam int SEQ_BYTES = 1;
`else
    localparam int SEQ_BYTES = 0;
`endif
    localparam int          FIFO_BYTES = PAYLOAD_BYTES - SEQ_BYTES;
    localparam int          FW         = $clog2(PAYLOAD_BYTES + 1);
    localparam logic [15:0] LEN_FIELD  = 16'(PAYLOAD_BYTES);

    logic [PW-1:0] p;
    logic [FW-1:0] fill;
    logic [7:0]    pay_mem [FIFO_BYTES];
    logic          stall_q;
    logic          active;
    int            pos;
    int            fill_w;
    int            off;
    int            slot;
    phase_t        ph;
    logic          last_pos;
    logic          resync;
    logic          accept;
    logic          in_data_ph;
    logic [7:0]    tx_byte;
    logic [47:0]   mac_shift;
    logic [1:0]    tx_dibit;

    assign pos        = int'(p);
    assign fill_w     = int'(fill);
    assign ph         = phase_of(pos);
    assign last_pos   = (pos == FRAME_LEN - 1);
    assign in_data_ph = (pos >= DATA_START);
    // A stall rise marks tail dibit 0 of the packer's frame.
    assign resync     = !stall_q && stall;

    // active keeps in_ready low in reset and for the first cycle after release
    assign in_ready = active && !in_data_ph && (fill_w < FIFO_BYTES);
    assign accept   = in_valid && in_ready;
    assign underrun = (pos == DATA_START) && (fill_w < FIFO_BYTES);

    // Frame position: free-running wrap, snapped to tail dibit 1 on a stall rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p       <= PW'(IFG_START);
            stall_q <= 1'b1;
            active  <= 1'b0;
        end else begin
            stall_q <= stall;
            active  <= 1'b1;
            if (resync)        p <= PW'(1);
            else if (last_pos) p <= '0;
            else               p <= p + 1'b1;
        end
    end

    // Fill count: grows on accept, emptied as the last data dibit goes out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        fill <= '0;
        else if (last_pos) fill <= '0;
        else if (accept)   fill <= fill + 1'b1;
    end

    // Payload storage; stale contents are masked by fill so no reset needed
    always_ff @(posedge clk) begin
        for (int i = 0; i < FIFO_BYTES; i++) begin
            if (accept && fill_w == i) pay_mem[i] <= in_data;
        end
    end

    // Sticky loss-of-lock flag: stall must be low exactly in the data phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    sync_err <= 1'b0;
        else if (stall == in_data_ph)  sync_err <= 1'b1;
    end

`ifdef ETH_SRC_SEQ_EN
    logic [7:0] seq;

    // Frame sequence number, advanced once the frame's last dibit is sent
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        seq <= '0;
        else if (last_pos) seq <= seq + 8'd1;
    end
`endif

    // Byte and dibit offset for the byte-serial phases
    always_comb begin
        tx_byte   = 8'h00;
        off       = 0;
        slot      = 0;
        mac_shift = SRC_MAC;
        case (ph)
            PH_SRC: begin
                off       = pos - SRC_START;
                mac_shift = SRC_MAC << (8 * (off >> 2));
                tx_byte   = mac_shift[47:40];
            end
            PH_LEN: begin
                off     = pos - LEN_START;
                tx_byte = ((off >> 2) == 0) ? LEN_FIELD[15:8] : LEN_FIELD[7:0];
            end
            PH_DATA: begin
                off  = pos - DATA_START;
                slot = (off >> 2) - SEQ_BYTES;
                for (int i = 0; i < FIFO_BYTES; i++) begin
                    if (slot == i && i < fill_w) tx_byte = pay_mem[i];
                end
`ifdef ETH_SRC_SEQ_EN
                if ((off >> 2) == 0) tx_byte = seq;
`endif
            end
            default: ;
        endcase
    end

    byte_to_dibit u_b2d (
        .data  (tx_byte),
        .sel   (off[1:0]),
        .dibit (tx_dibit)
    );

    // Line outputs decoded from position only; stall never reaches them
    always_comb begin
        axiov = 1'b0;
        axiod = 2'b00;
        case (ph)
            PH_PRE: begin
                axiov = 1'b1;
                axiod = (pos == SFD_POS) ? SFD_DIBIT : PRE_DIBIT;
            end
            PH_DEST: begin
                axiov = 1'b1;
                axiod = BCAST_DIBIT;
            end
            PH_SRC, PH_LEN, PH_DATA: begin
                axiov = 1'b1;
                axiod = tx_dibit;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_eth_frame_source.sv
// tb_eth_frame_source: directed sequence with random payload, checked each
// cycle against a frame-level model built from byte lists.
module tb_eth_frame_source;

    localparam int          PB  = 5;
    localparam logic [47:0] MAC = 48'h69695A065491;
    localparam int          FL  = 152 + 4 * PB;
`ifdef ETH_SRC_SEQ_EN
    localparam int SEQ = 1;
`else
    localparam int SEQ = 0;
`endif
    localparam int CAP = PB - SEQ;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       stall = 1'b1;
    logic       in_ready, axiov, underrun, sync_err;
    logic [1:0] axiod;

    int errors = 0;
    int checks = 0;

    // reference model state
    int         mpos = 16;
    int         ppos = 16;
    int         cyc = 0;
    int         mseq = 0;
    bit         mactive = 0;
    bit         mprev = 1;
    bit         msync = 0;
    bit         skew_req = 0;
    int         ur_seen = 0;
    logic [7:0] mbytes[$];
    logic [7:0] src_q[$];

    typedef struct {
        int         c;
        logic       v;
        logic [1:0] d;
    } dir_t;
    dir_t dirs[$];

    eth_frame_source dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .stall    (stall),
        .axiov    (axiov),
        .axiod    (axiod),
        .underrun (underrun),
        .sync_err (sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [7:0] frame_byte(input int k);
        logic [47:0] m;
        int j;
        if (k < 6) begin
            m = MAC >> (8 * (5 - k));
            return m[7:0];
        end
        if (k == 6) return 8'(PB / 256);
        if (k == 7) return 8'(PB % 256);
        j = k - 8;
        if (SEQ == 1) begin
            if (j == 0) return 8'(mseq);
            j = j - 1;
        end
        if (j < mbytes.size()) return mbytes[j];
        return 8'h00;
    endfunction

    function automatic bit exp_ready();
        return mactive && (mpos < 152) && (mbytes.size() < CAP);
    endfunction

    task automatic expected_line(input int pos, output logic v, output logic [1:0] d);
        logic [7:0] b;
        v = 1'b0;
        d = 2'b00;
        if (pos >= 64) begin
            v = 1'b1;
            if (pos < 95) d = 2'b01;
            else if (pos < 120) d = 2'b11;
            else begin
                b = frame_byte((pos - 120) / 4);
                d = 2'((b >> (2 * ((pos - 120) % 4))) & 8'h03);
            end
        end
    endtask

    task automatic check_outputs();
        logic       ev;
        logic [1:0] ed;
        dir_t       dr;
        expected_line(mpos, ev, ed);
        chk("axiov", axiov, ev);
        chk("axiod", axiod, ed);
        chk("in_ready", in_ready, exp_ready());
        chk("underrun", underrun, (mpos == 152) && (mbytes.size() < CAP));
        chk("sync_err", sync_err, msync);
        if (underrun === 1'b1) ur_seen++;
        if (dirs.size() > 0 && rst_n === 1'b1 && dirs[0].c == cyc) begin
            dr = dirs.pop_front();
            chk("dir_axiov", axiov, dr.v);
            chk("dir_axiod", axiod, dr.d);
        end
    endtask

    task automatic drive_inputs();
        in_valid = (src_q.size() > 0) && ($urandom_range(0, 3) != 0);
        in_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
        stall    = (ppos < 152);
    endtask

    task automatic advance();
        int nxt;
        if (!rst_n) begin
            mpos = 16; ppos = 16; mseq = 0;
            mactive = 0; mprev = 1; msync = 0; skew_req = 0;
            mbytes.delete();
            return;
        end
        if (in_valid && exp_ready()) mbytes.push_back(src_q.pop_front());
        if ((!stall && mpos < 152) || (stall && mpos >= 152)) msync = 1;
        if (!mprev && stall) nxt = 1;
        else nxt = (mpos + 1) % FL;
        if (mpos == FL - 1) begin
            mbytes.delete();
            mseq = (mseq + 1) % 256;
        end
        mprev = stall;
        mpos = nxt;
        mactive = 1;
        ppos = (ppos + 1 + (skew_req ? 1 : 0)) % FL;
        skew_req = 0;
        cyc++;
    endtask

    task automatic tick(input bit rst_val);
        @(negedge clk);
        check_outputs();
        if (rst_val && !rst_n) cyc = 0;
        rst_n = rst_val;
        drive_inputs();
        advance();
    endtask

    task automatic run_to(input int target);
        int n;
        n = 0;
        while (mpos != target && n < 2 * FL) begin
            tick(1'b1);
            n++;
        end
    endtask

    task automatic add_dir(input int c, input logic v, input logic [1:0] d);
        dirs.push_back('{c, v, d});
    endtask

    task automatic push_random(input int n);
        for (int i = 0; i < n; i++) src_q.push_back(8'($urandom_range(0, 255)));
    endtask

    initial begin
        #600000;
        $display("FAIL timeout: run did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // cycle numbers counted from reset release (p = 16 at cycle 0)
        add_dir(47, 1'b0, 2'b00);
        add_dir(48, 1'b1, 2'b01);
        add_dir(78, 1'b1, 2'b01);
        add_dir(79, 1'b1, 2'b11);
        add_dir(80, 1'b1, 2'b11);
        add_dir(104, 1'b1, 2'b01);
        add_dir(105, 1'b1, 2'b10);
        add_dir(106, 1'b1, 2'b10);
        add_dir(107, 1'b1, 2'b01);
        for (int i = 128; i < 132; i++) add_dir(i, 1'b1, 2'b00);
        add_dir(132, 1'b1, 2'b01);
        add_dir(133, 1'b1, 2'b01);
        add_dir(134, 1'b1, 2'b00);
        add_dir(135, 1'b1, 2'b00);
`ifndef ETH_SRC_SEQ_EN
        add_dir(136, 1'b1, 2'b01);
        add_dir(137, 1'b1, 2'b01);
        add_dir(138, 1'b1, 2'b10);
        add_dir(139, 1'b1, 2'b10);
        add_dir(140, 1'b1, 2'b01);
        add_dir(141, 1'b1, 2'b00);
        add_dir(142, 1'b1, 2'b00);
        add_dir(143, 1'b1, 2'b00);
`endif
        add_dir(156, 1'b0, 2'b00);

        src_q.push_back(8'hA5);
        src_q.push_back(8'h01);
        src_q.push_back(8'h02);
        src_q.push_back(8'h03);
        src_q.push_back(8'h04);

        // reset, release, first frame
        repeat (3) tick(1'b0);
        repeat (165) tick(1'b1);

        // random frames; frame 1 is short of bytes
        for (int f = 0; f < 4; f++) begin
            run_to(0);
            ur_seen = 0;
            if (f == 1) begin
                src_q.delete();
                push_random(2);
            end else if (f == 3) begin
                push_random($urandom_range(0, PB));
            end else begin
                push_random(PB);
            end
            run_to(153);
            if (f == 0) chk("no_underrun_full", 8'(ur_seen), 8'd0);
            if (f == 1) chk("underrun_once", 8'(ur_seen), 8'd1);
        end

        // packer runs one cycle ahead: early stall fall, then resync on stall rise
        run_to(0);
        push_random(PB);
        run_to(100);
        skew_req = 1;
        run_to(5);
        chk("sync_err_set", sync_err, 1'b1);
        push_random(PB);
        run_to(153);
        run_to(20);
        chk("sync_err_sticky", sync_err, 1'b1);

        // reset pulse in the middle of the data phase
        run_to(0);
        push_random(PB);
        run_to(160);
        tick(1'b0);
        #1;
        chk("axiov_in_reset", axiov, 1'b0);
        chk("in_ready_in_reset", in_ready, 1'b0);
        tick(1'b0);
        tick(1'b1);
        chk("sync_err_cleared", sync_err, 1'b0);
        run_to(0);
        push_random(PB);
        run_to(0);
        push_random(PB);
        run_to(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
